// File: rtl/data_mem_responder.sv
// Byte/half/word data-memory responder with a valid/ready request and response channel and WAIT_CYCLES wait states.
// Latency: response valid WAIT_CYCLES+1 edges after accept. Backpressure: a low resp_ready_i holds RESP with outputs stable.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          in_range;
    logic          misalign;
    logic          illegal;
    logic          err_c;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [15:0]   half;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          wr_en;

    always_comb begin
        in_range = ({1'b0, addr_q} < LIMIT);
        idx      = addr_q[AW+1:2];
        word     = mem[idx];
        shifted  = word >> {addr_q[1:0], 3'b000};
        half     = addr_q[1] ? word[31:16] : word[15:0];

        misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        if (we_q)
            illegal = (f3_q[2] || (f3_q[1:0] == 2'b11));
        else
            illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
        err_c = misalign || illegal || !in_range;

        case (f3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{half[15]}}, half};
            3'b010:  ld_data = word;
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b101:  ld_data = {16'd0, half};
            default: ld_data = 32'd0;
        endcase

        case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase

        wr_en = (state == ACCESS) && we_q && !err_c;
    end

    // The FSM resets asynchronously to IDLE, so a low rst at a committing edge already removes wr_en.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            f3_q         <= 3'd0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        we_q        <= req_we_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        f3_q        <= req_funct3_i;
                        req_ready_o <= 1'b0;
                        cnt         <= 4'(WAIT_CYCLES);
                        state       <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ACCESS;
                end
                ACCESS: begin
                    resp_rdata_o <= (err_c || we_q) ? 32'd0 : ld_data;
                    resp_err_o   <= err_c;
                    resp_valid_o <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [2:0]  req_f3;

    logic        req_valid0, req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_f3),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(1'b1),
        .req_addr_i(32'h40), .req_wdata_i(32'h0BAD_F00D), .req_funct3_i(3'b010),
        .resp_valid_o(resp_valid0), .resp_ready_i(1'b1),
        .resp_rdata_o(resp_rdata0), .resp_err_o(resp_err0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wdat, input logic [2:0] f3);
        int t;
        req_we    = we;
        req_addr  = a;
        req_wdata = wdat;
        req_f3    = f3;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            step();
            t++;
        end
        chk("accept_timeout", 32'(t < 50), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wdat, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat);
        issue(we, a, wdat, f3);
        wait_resp(lat);
        rd = resp_rdata;
        er = resp_err;
        step();
    endtask

    logic [31:0] rd, held;
    logic        er;
    int          lat, bad;
    int          acc[$];
    int          rise[$];
    int          e;
    logic        pre_rdy, pre_v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_f3 = '0;
        resp_ready = 1'b1;
        req_valid0 = 1'b0;
        step(); step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        step();
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd3);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("ready_after_hs", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_data", rd, 32'hDEAD_BEEF);
        chk("lw_err", 32'(er), 32'd0);

        xact(1'b1, 32'h11, 32'hAAAA_AA7F, 3'b000, rd, er, lat);
        chk("sb_err", 32'(er), 32'd0);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw_after_sb", rd, 32'hDEAD_7FEF);
        xact(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
        chk("lb", rd, 32'hFFFF_FFDE);
        xact(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
        chk("lbu", rd, 32'h0000_00DE);
        xact(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
        chk("lh", rd, 32'hFFFF_DEAD);
        xact(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lat);
        chk("lhu", rd, 32'h0000_DEAD);

        xact(1'b0, 32'h11, 32'h0, 3'b010, rd, er, lat);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        xact(1'b1, 32'h13, 32'h0000_1234, 3'b001, rd, er, lat);
        chk("sh_mis_err", 32'(er), 32'd1);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("sh_mis_nowrite", rd, 32'hDEAD_7FEF);
        xact(1'b0, 32'h1000, 32'h0, 3'b010, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        xact(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
        chk("f3_011_err", 32'(er), 32'd1);
        xact(1'b1, 32'h10, 32'h0, 3'b100, rd, er, lat);
        chk("st_f3_100_err", 32'(er), 32'd1);

        resp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        wait_resp(lat);
        chk("bp_lat", 32'(lat), 32'd3);
        held = resp_rdata;
        bad = 0;
        repeat (10) begin
            step();
            if (!resp_valid || resp_rdata !== held || req_ready) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_data", held, 32'hDEAD_7FEF);
        resp_ready = 1'b1;
        step();
        chk("bp_valid_drop", 32'(resp_valid), 32'd0);
        chk("bp_ready_back", 32'(req_ready), 32'd1);

        xact(1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, rd, er, lat);
        xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
        chk("pre_rst_lw", rd, 32'hCAFE_F00D);
        issue(1'b1, 32'h20, 32'h1234_5678, 3'b010);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        chk("midrst_err", 32'(resp_err), 32'd0);
        step(); step();
        rst = 1'b1;
        bad = 0;
        repeat (6) begin
            step();
            if (resp_valid) bad++;
        end
        chk("midrst_no_resp", 32'(bad), 32'd0);
        chk("midrst_ready_back", 32'(req_ready), 32'd1);
        xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
        chk("midrst_mem_kept", rd, 32'hCAFE_F00D);

        req_valid0 = 1'b1;
        e = 0;
        repeat (12) begin
            pre_rdy = req_ready0;
            pre_v   = resp_valid0;
            step();
            e++;
            if (pre_rdy) acc.push_back(e);
            if (!pre_v && resp_valid0) rise.push_back(e);
        end
        req_valid0 = 1'b0;
        chk("w0_accepts", 32'(acc.size() >= 3), 32'd1);
        chk("w0_rises", 32'(rise.size() >= 2), 32'd1);
        if (acc.size() >= 3 && rise.size() >= 2) begin
            chk("w0_space1", 32'(acc[1] - acc[0]), 32'd3);
            chk("w0_space2", 32'(acc[2] - acc[1]), 32'd3);
            chk("w0_lat1", 32'(rise[0] - acc[0]), 32'd1);
            chk("w0_lat2", 32'(rise[1] - acc[1]), 32'd1);
        end
        chk("w0_err", 32'(resp_err0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the RV32I core's load/store port. It accepts one request at a time over a valid/ready request channel and performs byte, half or word accesses selected by the instruction's funct3. It inserts a programmable number of wait states and returns read data or an error over a valid/ready response channel. It is the memory-side endpoint that replaces the zero-latency combinational data memory when the core moves to a stall-capable datapath.

## Interface
- `DEPTH_WORDS`, default 1024: storage size in 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
- `WAIT_CYCLES`, default 2: wait states inserted between accept and access; legal range 0..15.
- `clk` input 1: clock; all state changes on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: request present.
- `req_ready_o` output 1: responder can accept a request.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_addr_i` input 32: byte address.
- `req_wdata_i` input 32: store data; the low byte or low half is used for SB/SH.
- `req_funct3_i` input 3: access size and sign (RV32I load/store funct3 encoding).
- `resp_valid_o` output 1: response present.
- `resp_ready_i` input 1: core accepts the response.
- `resp_rdata_o` output 32: load result, extended; 0 for stores and errors.
- `resp_err_o` output 1: access was misaligned, out of range, or had an illegal funct3.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i & req_ready_o`, capture we/addr/wdata/funct3.
  - Go to WAIT with counter=`WAIT_CYCLES`; if `WAIT_CYCLES`=0, go directly to ACCESS.
- WAIT: counter decrements each cycle. Move to ACCESS on the edge where the counter is 1.
- ACCESS: one cycle.
  - Check the captured request.
  - Perform the store (memory write on the exiting edge) or the read.
  - Register rdata and err, then go to RESP.
- RESP:
  - `resp_valid_o`=1, with rdata and err held stable.
  - On `resp_valid_o & resp_ready_i`, go to IDLE.
- Request inputs are ignored outside the accept edge. At most one request is outstanding.
- Loads, little-endian:
  - LB 000: sign-extend the byte at addr.
  - LH 001: sign-extend the half at addr.
  - LW 010: word at addr.
  - LBU 100: zero-extend the byte.
  - LHU 101: zero-extend the half.
- Stores:
  - SB 000: write only byte lane addr[1:0].
  - SH 001: write lanes addr[1]*2 and +1.
  - SW 010: write all 4 lanes.
  - Untouched lanes keep their value.
- Error conditions (no memory update, rdata=0, err=1):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr ≥ 4*`DEPTH_WORDS`, compared on all 32 bits with no wrap-around.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 other than 000, 001 or 010.
- Memory array is not cleared by reset; contents persist across reset.

## Timing
- Reset asserted: FSM to IDLE immediately, asynchronously. Output values while asserted:
  - `req_ready_o`=0.
  - `resp_valid_o`=0.
  - `resp_rdata_o`=0.
  - `resp_err_o`=0.
- Reset deasserted: `req_ready_o`=1 from the first cycle after deassertion.
- Latency: for a request accepted on edge E0, `resp_valid_o` rises after edge E0+`WAIT_CYCLES`+1.
  - `WAIT_CYCLES`=2: accept E0, WAIT after E0 and E1, ACCESS after E2, RESP after E3.
- Store commit: memory is written on the edge leaving ACCESS; a load issued afterwards observes the new data.
- Response handshake: on the edge that completes it, the FSM returns to IDLE.
  - `req_ready_o` is 1 in the following cycle.
  - No request is accepted in the same cycle as the response handshake.
  - Minimum spacing between accepts is `WAIT_CYCLES`+3 cycles.
- Backpressure: `resp_ready_i` held low keeps the FSM in RESP indefinitely with outputs stable.
- Reset mid-operation, in WAIT or RESP: the request is dropped with no response.
- Reset in ACCESS: a store is suppressed if `rst` is low at the committing edge; the memory write is gated by `rst` high.
- All outputs are decoded from registered state; there is no combinational path from request inputs to outputs.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 with `resp_ready_i`=1: response 0xDEADBEEF, err=0. `resp_valid_o` rises exactly 3 edges after each accept (`WAIT_CYCLES`=2).
- After the above:
  - SB 0x7F to 0x11 → LW 0x10 gives 0xDEAD7FEF.
  - LB 0x13 gives 0xFFFFFFDE.
  - LBU 0x13 gives 0x000000DE.
  - LH 0x12 gives 0xFFFFDEAD.
  - LHU 0x12 gives 0x0000DEAD.
- Errors:
  - LW 0x11 → err=1, rdata=0.
  - SH 0x13 → err=1, and word 0x10 unchanged.
  - LW 0x1000 with `DEPTH_WORDS`=1024 → err=1.
  - Load funct3=011 → err=1.
- Hold `resp_ready_i`=0 for 10 cycles in RESP: `resp_valid_o` and data stay stable and `req_ready_o`=0. Raise `resp_ready_i`: handshake completes, then `req_ready_o`=1 on the next cycle.
- Assert `rst` while a SW 0x12345678 to 0x20 is in WAIT: outputs go to reset values at once and no response is produced. A later LW 0x20 returns the prior contents.
- With `WAIT_CYCLES`=0, back-to-back requests with `req_valid_i` held high: accepts are spaced 3 cycles apart and `resp_valid_o` rises 1 edge after each accept.
